// File: rtl/muldiv4_sequencer_if.sv
// Request/response bundle for muldiv4_sequencer.
//   master: drives start/op/a/b, observes busy/done/result/dbz (requester side)
//   slave : the sequencer itself
interface muldiv4_sequencer_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic                 start;
  logic                 op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic                 dbz;

  modport master (output start, op, a, b, input busy, done, result, dbz);
  modport slave  (input start, op, a, b, output busy, done, result, dbz);
endinterface

// File: rtl/muldiv4_sequencer.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) sequencer.
// One step per clock, WIDTH steps per operation, fixed latency.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of muldiv4_sequencer_if:
//           start/op/a/b in; busy/done/result/dbz out (all registered)
//   result: multiply -> product, divide -> {remainder, quotient}
// WIDTH must be at least 2.
module muldiv4_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  muldiv4_sequencer_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned RW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            op_q, op_d;
  logic [RW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [RW-1:0]   result_q, result_d;
  logic            dbz_q, dbz_d;
  logic            busy_q, done_q;
  logic            armed_q;
  logic            accept;
  logic [RW-1:0]   step;
  logic [WIDTH:0]  trial;

  // One iteration of the active algorithm.
  // Divide keeps {partial remainder, dividend/quotient} in acc; the trial
  // subtract uses the remainder shifted left with the next dividend bit.
  always_comb begin
    step  = acc_q;
    trial = '0;
    if (!op_q) begin
      step = acc_q + (mcand_q & {RW{opb_q[0]}});
    end else begin
      trial = acc_q[RW-1:WIDTH-1] - {1'b0, opb_q};
      if (!trial[WIDTH]) begin
        step = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        step = {acc_q[RW-2:0], 1'b0};
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    // armed_q blocks the first edge after reset release.
    accept   = armed_q && bus.start && (state_q == IDLE);

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = bus.op;
          mcand_d = RW'(bus.a);
          opb_d   = bus.b;
          acc_d   = bus.op ? RW'(bus.a) : '0;
          cnt_d   = '0;
          dbz_d   = bus.op && (bus.b == '0);
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step;
        cnt_d = cnt_q + CW'(1);
        if (!op_q) begin
          mcand_d = mcand_q << 1;
          opb_d   = opb_q >> 1;
        end
        // Final step lands directly in result; acc is never exposed.
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d = step;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      mcand_q  <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
      busy_q   <= (state_d == RUN);
      done_q   <= (state_d == DONE);
      armed_q  <= 1'b1;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.dbz    = dbz_q;

endmodule

// File: tb/tb_muldiv4_sequencer.sv
// Scoreboard bench for muldiv4_sequencer: directed vectors push expected
// {result, dbz, done cycle}; a negedge monitor pops and compares on done.
module tb_muldiv4_sequencer;

  localparam int unsigned W = 4;

  typedef struct {
    logic [2*W-1:0] res;
    logic           dbz;
    int             cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_push = 0;
  int   n_done = 0;
  logic [2*W-1:0] hold_exp = '0;
  exp_t q[$];

  muldiv4_sequencer_if #(.WIDTH(W)) bus ();

  muldiv4_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare on every done; result must otherwise hold its last value.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_exp = '0;
    end else begin
      check("busy_done_exclusive", 32'(bus.busy & bus.done), 32'd0);
      if (bus.done) begin
        n_done++;
        if (q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("result", 32'(bus.result), 32'(e.res));
          check("dbz", 32'(bus.dbz), 32'(e.dbz));
          check("done_cycle", 32'(cyc), 32'(e.cyc));
          hold_exp = e.res;
        end
      end else begin
        check("result_hold", 32'(bus.result), 32'(hold_exp));
      end
    end
  end

  task automatic push(input logic [2*W-1:0] res, input logic dbz);
    exp_t e;
    e.res = res;
    e.dbz = dbz;
    e.cyc = cyc + int'(W);
    q.push_back(e);
    n_push++;
  endtask

  // Single request from IDLE; returns with the DUT back in IDLE.
  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] res, input logic dbz);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    push(res, dbz);
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    repeat (W + 1) @(posedge clk);
  endtask

  task automatic check_zero(input string name);
    check({name, "_busy"},   32'(bus.busy),   32'd0);
    check({name, "_done"},   32'(bus.done),   32'd0);
    check({name, "_result"}, 32'(bus.result), 32'd0);
    check({name, "_dbz"},    32'(bus.dbz),    32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 4'd2; bus.b = 4'd2;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    // First edge with reset released must ignore start.
    @(posedge clk); #1;
    check("first_edge_ignored", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("still_idle", 32'(bus.busy), 32'd0);

    run_op(1'b0, 4'd15, 4'd15, 8'hE1, 1'b0);
    run_op(1'b1, 4'd13, 4'd3,  8'h14, 1'b0);
    run_op(1'b1, 4'd9,  4'd0,  8'h9F, 1'b1);
    run_op(1'b0, 4'd2,  4'd3,  8'h06, 1'b0);

    // Start pulsed during RUN with new operands is ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 4'd5; bus.b = 4'd3;
    @(posedge clk); #1;
    push(8'h0F, 1'b0);
    bus.start = 1'b0;
    @(negedge clk); @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b1; bus.a = 4'd7; bus.b = 4'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    repeat (3) @(posedge clk); #1;
    check("ignored_start_idle", 32'(bus.busy), 32'd0);
    check("ignored_start_dbz", 32'(bus.dbz), 32'd0);

    // Back-to-back with start held high: accepts every W+2 cycles.
    begin
      logic          ops [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [W-1:0]  as  [4] = '{4'd7, 4'd14, 4'd8, 4'd11};
      logic [W-1:0]  bs  [4] = '{4'd9, 4'd4, 4'd0, 4'd12};
      logic [2*W-1:0] rs [4] = '{8'h3F, 8'h23, 8'h8F, 8'h84};
      logic          ds  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      @(negedge clk);
      bus.start = 1'b1;
      for (int i = 0; i < 4; i++) begin
        bus.op = ops[i]; bus.a = as[i]; bus.b = bs[i];
        if (i == 0) @(posedge clk);
        else repeat (W + 2) @(posedge clk);
        #1;
        push(rs[i], ds[i]);
        @(negedge clk);
        if (i == 3) bus.start = 1'b0;
      end
      repeat (W + 2) @(posedge clk);
    end

    // Reset in RUN cycle 2: immediate zero outputs, no done.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 4'd9; bus.b = 4'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    run_op(1'b0, 4'd6, 4'd7, 8'h2A, 1'b0);

    for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    check("done_count", 32'(n_done), 32'(n_push));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
